gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Owns the single GPR write port and shares it among three write-back sources: single-cycle ALU, load/store unit (LSU) and multi-cycle multiply/divide unit (MDU).
- Keeps a 32-entry pending-write scoreboard so decode stalls on RAW/WAW hazards against outstanding LSU/MDU destinations.
- Sits between the execute-stage result sources and the GPR write inputs (RegWrite, WriteRegisterSelect, WriteData).

Parameters:
- DATA_W, 32, write-back data width.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous active-high reset.
- AluWrite  in  1  ALU result valid this cycle; cannot be back-pressured.
- AluReg  in  5  ALU destination register.
- AluData  in  DATA_W  ALU result.
- LsuReq  in  1  LSU write-back request; held until LsuAck.
- LsuReg  in  5  LSU destination.
- LsuData  in  DATA_W  LSU load data.
- LsuAck  out  1  LSU request granted this cycle (combinational).
- MduReq  in  1  MDU write-back request; held until MduAck.
- MduReg  in  5  MDU destination.
- MduData  in  DATA_W  MDU result.
- MduAck  out  1  MDU request granted this cycle (combinational).
- IssueValid  in  1  decode issues a multi-cycle (LSU load/MDU) op this cycle.
- IssueReg  in  5  its destination.
- ReadRegister1, ReadRegister2  in  5 each  decode source operands.
- Use1, Use2  in  1 each  source operand actually read.
- Stall  out  1  hazard stall to decode (combinational from registered busy bits).
- RegWrite  out  1  registered GPR write enable.
- WriteRegisterSelect  out  5  registered GPR write address.
- WriteData  out  DATA_W  registered GPR write data.
- ContentionCount  out  CNT_W  cycles in which any LSU/MDU request waited.

Behaviour:
- Reset: RegWrite=0, WriteRegisterSelect=0, WriteData=0, busy[31:0]=0, ContentionCount=0, round-robin pointer=LSU. Reset mid-transaction discards pending requests; requesters re-request.
- Latency: grant in cycle N -> RegWrite/WriteRegisterSelect/WriteData valid in N+1 (registered), written to GPR at the N+1 posedge.
- Arbitration per cycle:
  - AluWrite && AluReg!=0 always wins.
  - Otherwise one of LSU/MDU wins: if both request, the pointer chooses; pointer flips to the other unit after each LSU/MDU grant; a lone requester wins regardless of pointer.
- Ack rules:
  - Ack is asserted only in the grant cycle.
  - Requester must hold Req/Reg/Data stable until Ack; it may present a new request the next cycle.
  - Ack with Req low is illegal and never generated.
- R0 handling:
  - A request with Reg==0 is acked immediately, even under ALU priority (it does not use the port), and produces no write.
  - An ALU write to R0 is dropped and does not block the LSU/MDU.
  - RegWrite is never asserted with WriteRegisterSelect==0.
- No grant in a cycle -> RegWrite=0 next cycle; WriteRegisterSelect/WriteData hold their previous values.
- Scoreboard:
  - IssueValid && IssueReg!=0 sets busy[IssueReg] at the posedge.
  - An LSU/MDU grant to reg r clears busy[r] at the same posedge.
  - Set and clear of the same reg in the same cycle -> set wins.
  - ALU writes never touch busy.
- Stall = (Use1 && busy[ReadRegister1]) || (Use2 && busy[ReadRegister2]) || (IssueValid && busy[IssueReg]).
  - busy[0] is constant 0.
  - Stall does not block grants in the same cycle.
  - Decode must hold IssueValid/IssueReg while Stall is high; a stalled issue does not set busy.
- ContentionCount increments by 1 for each cycle where an LSU or MDU Req is high without its Ack; saturates at all-ones.

Test Plan:
- Reset then idle 5 cycles -> RegWrite=0, Stall=0, ContentionCount=0, all outputs 0.
- AluWrite, AluReg=5, AluData=0xDEADBEEF, with LsuReq, LsuReg=6 in the same cycle -> next cycle RegWrite=1, addr 5, data DEADBEEF; LsuAck one cycle later; RegWrite addr 6 one cycle after that; ContentionCount=1.
- LsuReq and MduReq held continuously from reset with AluWrite=0 -> grants alternate LSU, MDU, LSU, MDU; each Ack lasts exactly one cycle.
- IssueValid, IssueReg=8, then ReadRegister1=8 with Use1=1 -> Stall=1 until MduReq to reg 8 is acked; Stall=0 in the cycle after the ack.
- Same cycle: IssueValid reg 9 and LsuAck for reg 9 -> busy[9] stays 1; a WAW issue to reg 9 raises Stall.
- AluWrite to R0, and MduReq to R0 in the same cycle -> MduAck immediate, RegWrite stays 0, busy unchanged.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between ALU, LSU and MDU write-back sources and
// keeps a busy scoreboard of outstanding LSU/MDU destinations to stall decode on hazards.
module gpr_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AluWrite,
    input  logic [4:0]        AluReg,
    input  logic [DATA_W-1:0] AluData,
    input  logic              LsuReq,
    input  logic [4:0]        LsuReg,
    input  logic [DATA_W-1:0] LsuData,
    output logic              LsuAck,
    input  logic              MduReq,
    input  logic [4:0]        MduReg,
    input  logic [DATA_W-1:0] MduData,
    output logic              MduAck,
    input  logic              IssueValid,
    input  logic [4:0]        IssueReg,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    input  logic              Use1,
    input  logic              Use2,
    output logic              Stall,
    output logic              RegWrite,
    output logic [4:0]        WriteRegisterSelect,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  ContentionCount
);

    typedef enum logic { PTR_LSU = 1'b0, PTR_MDU = 1'b1 } rr_ptr_e;

    rr_ptr_e           ptr_q, ptr_d;
    logic [31:0]       busy_q, busy_d;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        wsel_q, wsel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic alu_win, lsu_port, mdu_port, lsu_grant, mdu_grant;
    logic issue_set, waiting;

    // Requests to R0 never compete for the port; they are acked on sight.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        lsu_grant = 1'b0;
        mdu_grant = 1'b0;
        alu_win   = AluWrite && (AluReg != 5'd0);
        lsu_port  = LsuReq && (LsuReg != 5'd0);
        mdu_port  = MduReq && (MduReg != 5'd0);
        if (!alu_win) begin
            if (lsu_port && mdu_port) begin
                lsu_grant = (ptr_q == PTR_LSU);
                mdu_grant = (ptr_q == PTR_MDU);
            end else begin
                lsu_grant = lsu_port;
                mdu_grant = mdu_port;
            end
        end
    end

    assign LsuAck = LsuReq && ((LsuReg == 5'd0) || lsu_grant);
    assign MduAck = MduReq && ((MduReg == 5'd0) || mdu_grant);

    assign Stall = (Use1 && busy_q[ReadRegister1]) ||
                   (Use2 && busy_q[ReadRegister2]) ||
                   (IssueValid && busy_q[IssueReg]);

    assign issue_set = IssueValid && !Stall && (IssueReg != 5'd0);
    assign waiting   = (LsuReq && !LsuAck) || (MduReq && !MduAck);

    always_comb begin
        reg_write_d = alu_win || lsu_grant || mdu_grant;
        wsel_d      = wsel_q;
        wdata_d     = wdata_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;

        if (alu_win) begin
            wsel_d  = AluReg;
            wdata_d = AluData;
        end else if (lsu_grant) begin
            wsel_d  = LsuReg;
            wdata_d = LsuData;
        end else if (mdu_grant) begin
            wsel_d  = MduReg;
            wdata_d = MduData;
        end

        if (lsu_grant) begin
            ptr_d          = PTR_MDU;
            busy_d[LsuReg] = 1'b0;
        end
        if (mdu_grant) begin
            ptr_d          = PTR_LSU;
            busy_d[MduReg] = 1'b0;
        end
        // Applied after the clears so a same-cycle re-issue keeps the register busy.
        if (issue_set) busy_d[IssueReg] = 1'b1;
        busy_d[0] = 1'b0;

        if (waiting && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the scoreboard is only 32 flops and must start clean, so it takes the reset.
            ptr_q       <= PTR_LSU;
            busy_q      <= '0;
            reg_write_q <= 1'b0;
            wsel_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            reg_write_q <= reg_write_d;
            wsel_q      <= wsel_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign RegWrite            = reg_write_q;
    assign WriteRegisterSelect = wsel_q;
    assign WriteData           = wdata_q;
    assign ContentionCount     = cnt_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus randomized traffic
// compared against a rule-level model of the write port and scoreboard.
module tb_gpr_wb_arbiter;

    localparam int TB_CNT_W = 5;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                CLK = 1'b0;
    logic                RST;
    logic                AluWrite, LsuReq, MduReq, IssueValid, Use1, Use2;
    logic [4:0]          AluReg, LsuReg, MduReg, IssueReg, ReadRegister1, ReadRegister2;
    logic [31:0]         AluData, LsuData, MduData;
    logic                LsuAck, MduAck, Stall, RegWrite;
    logic [4:0]          WriteRegisterSelect;
    logic [31:0]         WriteData;
    logic [TB_CNT_W-1:0] ContentionCount;

    int n_cmp = 0;
    int n_bad = 0;

    gpr_wb_arbiter #(.DATA_W(32), .CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .AluWrite(AluWrite), .AluReg(AluReg), .AluData(AluData),
        .LsuReq(LsuReq), .LsuReg(LsuReg), .LsuData(LsuData), .LsuAck(LsuAck),
        .MduReq(MduReq), .MduReg(MduReg), .MduData(MduData), .MduAck(MduAck),
        .IssueValid(IssueValid), .IssueReg(IssueReg),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .Use1(Use1), .Use2(Use2), .Stall(Stall),
        .RegWrite(RegWrite), .WriteRegisterSelect(WriteRegisterSelect),
        .WriteData(WriteData), .ContentionCount(ContentionCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs();
        AluWrite = 0; AluReg = 0; AluData = 0;
        LsuReq = 0; LsuReg = 0; LsuData = 0;
        MduReq = 0; MduReg = 0; MduData = 0;
        IssueValid = 0; IssueReg = 0;
        ReadRegister1 = 0; ReadRegister2 = 0; Use1 = 0; Use2 = 0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
    endtask

    // Build up state (pointer at MDU, busy bit, contention, write port) and reset it away.
    task automatic test_reset();
        idle_inputs();
        LsuReq = 1; LsuReg = 2; LsuData = 32'h11;
        tick();
        AluWrite = 1; AluReg = 3; AluData = 32'h55;
        IssueValid = 1; IssueReg = 7;
        MduReq = 1; MduReg = 2; MduData = 32'h22;
        repeat (3) tick();
        idle_inputs();
        do_reset();
        #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL reset_regwrite: got %0b want 0", RegWrite); end
        n_cmp++; if (WriteRegisterSelect !== 5'd0) begin n_bad++; $display("FAIL reset_wsel: got %0d want 0", WriteRegisterSelect); end
        n_cmp++; if (WriteData !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %0h want 0", WriteData); end
        n_cmp++; if (ContentionCount !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", ContentionCount); end
        Use1 = 1;
        for (int r = 0; r < 32; r++) begin
            ReadRegister1 = 5'(r);
            #1;
            n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_busy_r%0d: stall got %0b want 0", r, Stall); end
        end
        idle_inputs();
        repeat (5) tick();
        #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL idle_regwrite: got %0b want 0", RegWrite); end
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall: got %0b want 0", Stall); end
        n_cmp++; if (ContentionCount !== '0) begin n_bad++; $display("FAIL idle_count: got %0d want 0", ContentionCount); end
        n_cmp++; if (WriteRegisterSelect !== 5'd0 || WriteData !== 32'd0) begin n_bad++; $display("FAIL idle_port: got %0d/%0h want 0/0", WriteRegisterSelect, WriteData); end
        LsuReq = 1; LsuReg = 4; MduReq = 1; MduReg = 5;
        #1;
        n_cmp++; if (LsuAck !== 1'b1 || MduAck !== 1'b0) begin n_bad++; $display("FAIL reset_pointer: got lsu=%0b mdu=%0b want lsu=1 mdu=0", LsuAck, MduAck); end
        idle_inputs();
        tick();
    endtask

    task automatic test_alu_priority();
        idle_inputs();
        do_reset();
        AluWrite = 1; AluReg = 5; AluData = 32'hDEADBEEF;
        LsuReq = 1; LsuReg = 6; LsuData = 32'h12345678;
        #1;
        n_cmp++; if (LsuAck !== 1'b0) begin n_bad++; $display("FAIL alu_prio_lsu_wait: got %0b want 0", LsuAck); end
        tick();
        AluWrite = 0;
        #1;
        n_cmp++; if (RegWrite !== 1'b1 || WriteRegisterSelect !== 5'd5 || WriteData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_prio_write: got %0b/%0d/%0h want 1/5/deadbeef", RegWrite, WriteRegisterSelect, WriteData); end
        n_cmp++; if (LsuAck !== 1'b1) begin n_bad++; $display("FAIL alu_prio_lsu_ack: got %0b want 1", LsuAck); end
        tick();
        LsuReq = 0;
        #1;
        n_cmp++; if (RegWrite !== 1'b1 || WriteRegisterSelect !== 5'd6 || WriteData !== 32'h12345678) begin n_bad++; $display("FAIL alu_prio_lsu_write: got %0b/%0d/%0h want 1/6/12345678", RegWrite, WriteRegisterSelect, WriteData); end
        n_cmp++; if (ContentionCount !== TB_CNT_W'(1)) begin n_bad++; $display("FAIL alu_prio_count: got %0d want 1", ContentionCount); end
        n_cmp++; if (LsuAck !== 1'b0) begin n_bad++; $display("FAIL alu_prio_ack_drop: got %0b want 0", LsuAck); end
        tick();
        #1;
        n_cmp++; if (RegWrite !== 1'b0 || WriteRegisterSelect !== 5'd6 || WriteData !== 32'h12345678) begin n_bad++; $display("FAIL alu_prio_hold: got %0b/%0d/%0h want 0/6/12345678", RegWrite, WriteRegisterSelect, WriteData); end
    endtask

    task automatic test_round_robin();
        logic        exp_lsu;
        logic [31:0] exp_data;
        int          exp_cnt;
        idle_inputs();
        LsuReq = 1; LsuReg = 10; LsuData = 32'h100;
        MduReq = 1; MduReg = 11; MduData = 32'h200;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_lsu  = (i % 2 == 0);
            exp_data = exp_lsu ? LsuData : MduData;
            n_cmp++; if (LsuAck !== exp_lsu || MduAck !== !exp_lsu) begin n_bad++; $display("FAIL rr_ack_%0d: got lsu=%0b mdu=%0b want lsu=%0b", i, LsuAck, MduAck, exp_lsu); end
            tick();
            exp_cnt = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
            n_cmp++; if (RegWrite !== 1'b1 || WriteRegisterSelect !== (exp_lsu ? 5'd10 : 5'd11) || WriteData !== exp_data) begin n_bad++; $display("FAIL rr_write_%0d: got %0b/%0d/%0h want 1/%0d/%0h", i, RegWrite, WriteRegisterSelect, WriteData, exp_lsu ? 10 : 11, exp_data); end
            n_cmp++; if (ContentionCount !== TB_CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL rr_count_%0d: got %0d want %0d", i, ContentionCount, exp_cnt); end
            if (exp_lsu) LsuData = LsuData + 1;
            else MduData = MduData + 1;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_raw_stall();
        idle_inputs();
        do_reset();
        IssueValid = 1; IssueReg = 8;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL raw_issue_free: got %0b want 0", Stall); end
        tick();
        IssueValid = 0; ReadRegister1 = 8; Use1 = 0;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL raw_use1_masked: got %0b want 0", Stall); end
        Use1 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall_hold_%0d: got %0b want 1", i, Stall); end
            tick();
        end
        Use1 = 0; ReadRegister2 = 8; Use2 = 1;
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL raw_use2: got %0b want 1", Stall); end
        Use2 = 0; Use1 = 1;
        MduReq = 1; MduReg = 8; MduData = 32'hCAFE0008;
        #1;
        n_cmp++; if (MduAck !== 1'b1 || Stall !== 1'b1) begin n_bad++; $display("FAIL raw_ack_cycle: got ack=%0b stall=%0b want 1/1", MduAck, Stall); end
        tick();
        MduReq = 0;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL raw_after_ack: got %0b want 0", Stall); end
        n_cmp++; if (RegWrite !== 1'b1 || WriteRegisterSelect !== 5'd8 || WriteData !== 32'hCAFE0008) begin n_bad++; $display("FAIL raw_mdu_write: got %0b/%0d/%0h want 1/8/cafe0008", RegWrite, WriteRegisterSelect, WriteData); end
        idle_inputs();
        tick();
    endtask

    task automatic test_set_wins();
        idle_inputs();
        do_reset();
        IssueValid = 1; IssueReg = 9;
        LsuReq = 1; LsuReg = 9; LsuData = 32'h99;
        #1;
        n_cmp++; if (LsuAck !== 1'b1 || Stall !== 1'b0) begin n_bad++; $display("FAIL setwin_cycle: got ack=%0b stall=%0b want 1/0", LsuAck, Stall); end
        tick();
        LsuReq = 0;
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL setwin_waw: got %0b want 1", Stall); end
        IssueValid = 0; ReadRegister1 = 9; Use1 = 1;
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL setwin_raw: got %0b want 1", Stall); end
        // A stalled re-issue must not re-set the bit that the concurrent grant clears.
        idle_inputs();
        IssueValid = 1; IssueReg = 12;
        tick();
        MduReq = 1; MduReg = 12; MduData = 32'h12;
        #1;
        n_cmp++; if (Stall !== 1'b1 || MduAck !== 1'b1) begin n_bad++; $display("FAIL stalled_issue_cycle: got stall=%0b ack=%0b want 1/1", Stall, MduAck); end
        tick();
        MduReq = 0;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL stalled_issue_no_set: got %0b want 0", Stall); end
        idle_inputs();
        tick();
    endtask

    task automatic test_r0();
        idle_inputs();
        do_reset();
        IssueValid = 1; IssueReg = 4;
        tick();
        IssueValid = 0;
        AluWrite = 1; AluReg = 0; AluData = 32'hFFFF;
        MduReq = 1; MduReg = 0; MduData = 32'h1234;
        #1;
        n_cmp++; if (MduAck !== 1'b1) begin n_bad++; $display("FAIL r0_mdu_ack: got %0b want 1", MduAck); end
        tick();
        idle_inputs();
        Use1 = 1; ReadRegister1 = 4;
        #1;
        n_cmp++; if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL r0_no_write: got %0b want 0", RegWrite); end
        n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL r0_busy_kept: got %0b want 1", Stall); end
        n_cmp++; if (ContentionCount !== '0) begin n_bad++; $display("FAIL r0_count: got %0d want 0", ContentionCount); end
        idle_inputs();
        AluWrite = 1; AluReg = 0; LsuReq = 1; LsuReg = 7; LsuData = 32'h77;
        #1;
        n_cmp++; if (LsuAck !== 1'b1) begin n_bad++; $display("FAIL r0_alu_no_block: got %0b want 1", LsuAck); end
        tick();
        idle_inputs();
        AluWrite = 1; AluReg = 3; AluData = 32'h33; LsuReq = 1; LsuReg = 0; LsuData = 32'h44;
        #1;
        n_cmp++; if (RegWrite !== 1'b1 || WriteRegisterSelect !== 5'd7 || WriteData !== 32'h77) begin n_bad++; $display("FAIL r0_lsu_write: got %0b/%0d/%0h want 1/7/77", RegWrite, WriteRegisterSelect, WriteData); end
        n_cmp++; if (LsuAck !== 1'b1) begin n_bad++; $display("FAIL r0_lsu_under_alu: got %0b want 1", LsuAck); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (RegWrite !== 1'b1 || WriteRegisterSelect !== 5'd3 || WriteData !== 32'h33) begin n_bad++; $display("FAIL r0_alu_write: got %0b/%0d/%0h want 1/3/33", RegWrite, WriteRegisterSelect, WriteData); end
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        do_reset();
        AluWrite = 1; AluReg = 1; AluData = 32'hA; LsuReq = 1; LsuReg = 2; LsuData = 32'hB;
        repeat (CNT_MAX - 1) tick();
        #1;
        n_cmp++; if (ContentionCount !== TB_CNT_W'(CNT_MAX - 1)) begin n_bad++; $display("FAIL sat_below: got %0d want %0d", ContentionCount, CNT_MAX - 1); end
        repeat (6) tick();
        #1;
        n_cmp++; if (ContentionCount !== TB_CNT_W'(CNT_MAX)) begin n_bad++; $display("FAIL sat_hold: got %0d want %0d", ContentionCount, CNT_MAX); end
        n_cmp++; if (LsuAck !== 1'b0) begin n_bad++; $display("FAIL sat_lsu_blocked: got %0b want 0", LsuAck); end
        idle_inputs();
        tick();
    endtask

    // Randomized traffic against a rule-level model of port ownership, turn order and busy set.
    task automatic test_random();
        bit          mbusy[32];
        bit          turn_mdu, port_taken, lsu_wants, mdu_wants;
        int          winner, mcnt;
        bit          e_we, e_lsu_ack, e_mdu_ack, e_stall;
        logic [4:0]  e_sel;
        logic [31:0] e_data;
        bit          lsu_pend, mdu_pend, iss_pend;
        logic [4:0]  lsu_r, mdu_r, iss_r;
        logic [31:0] lsu_d, mdu_d;
        idle_inputs();
        do_reset();
        foreach (mbusy[r]) mbusy[r] = 0;
        turn_mdu = 0; mcnt = 0; e_we = 0; e_sel = 0; e_data = 0;
        lsu_pend = 0; mdu_pend = 0; iss_pend = 0;
        lsu_r = 0; mdu_r = 0; iss_r = 0; lsu_d = 0; mdu_d = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!lsu_pend && $urandom_range(0, 2) != 0) begin lsu_pend = 1; lsu_r = 5'($urandom_range(0, 7)); lsu_d = $urandom; end
            if (!mdu_pend && $urandom_range(0, 2) != 0) begin mdu_pend = 1; mdu_r = 5'($urandom_range(0, 7)); mdu_d = $urandom; end
            if (!iss_pend && $urandom_range(0, 2) == 0) begin iss_pend = 1; iss_r = 5'($urandom_range(0, 7)); end
            LsuReq = lsu_pend; LsuReg = lsu_r; LsuData = lsu_d;
            MduReq = mdu_pend; MduReg = mdu_r; MduData = mdu_d;
            IssueValid = iss_pend; IssueReg = iss_r;
            AluWrite = ($urandom_range(0, 2) == 0); AluReg = 5'($urandom_range(0, 7)); AluData = $urandom;
            ReadRegister1 = 5'($urandom_range(0, 7)); Use1 = 1'($urandom_range(0, 1));
            ReadRegister2 = 5'($urandom_range(0, 7)); Use2 = 1'($urandom_range(0, 1));
            #1;
            port_taken = AluWrite && (AluReg != 0);
            lsu_wants  = LsuReq && (LsuReg != 0);
            mdu_wants  = MduReq && (MduReg != 0);
            winner = 0;
            if (!port_taken) begin
                if (lsu_wants && mdu_wants) winner = turn_mdu ? 2 : 1;
                else if (lsu_wants) winner = 1;
                else if (mdu_wants) winner = 2;
            end
            e_lsu_ack = LsuReq && (LsuReg == 0 || winner == 1);
            e_mdu_ack = MduReq && (MduReg == 0 || winner == 2);
            e_stall   = (Use1 && mbusy[ReadRegister1]) || (Use2 && mbusy[ReadRegister2]) ||
                        (IssueValid && mbusy[IssueReg]);
            n_cmp++; if (LsuAck !== e_lsu_ack || MduAck !== e_mdu_ack) begin n_bad++; $display("FAIL rand_ack_%0d: got lsu=%0b mdu=%0b want lsu=%0b mdu=%0b", cyc, LsuAck, MduAck, e_lsu_ack, e_mdu_ack); end
            n_cmp++; if (Stall !== e_stall) begin n_bad++; $display("FAIL rand_stall_%0d: got %0b want %0b", cyc, Stall, e_stall); end
            if (port_taken) begin e_we = 1; e_sel = AluReg; e_data = AluData; end
            else if (winner == 1) begin e_we = 1; e_sel = LsuReg; e_data = LsuData; end
            else if (winner == 2) begin e_we = 1; e_sel = MduReg; e_data = MduData; end
            else e_we = 0;
            if (winner == 1) begin mbusy[LsuReg] = 0; turn_mdu = 1; end
            if (winner == 2) begin mbusy[MduReg] = 0; turn_mdu = 0; end
            if (IssueValid && !e_stall && IssueReg != 0) mbusy[IssueReg] = 1;
            if (((LsuReq && !e_lsu_ack) || (MduReq && !e_mdu_ack)) && mcnt < CNT_MAX) mcnt++;
            tick();
            n_cmp++; if (RegWrite !== e_we || WriteRegisterSelect !== e_sel || WriteData !== e_data) begin n_bad++; $display("FAIL rand_port_%0d: got %0b/%0d/%0h want %0b/%0d/%0h", cyc, RegWrite, WriteRegisterSelect, WriteData, e_we, e_sel, e_data); end
            n_cmp++; if (ContentionCount !== TB_CNT_W'(mcnt)) begin n_bad++; $display("FAIL rand_count_%0d: got %0d want %0d", cyc, ContentionCount, mcnt); end
            if (e_lsu_ack) lsu_pend = 0;
            if (e_mdu_ack) mdu_pend = 0;
            if (iss_pend && !e_stall) iss_pend = 0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        do_reset();
        test_reset();
        test_alu_priority();
        test_round_robin();
        test_raw_stall();
        test_set_wins();
        test_r0();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
